// File: rtl/password_pkg.sv
// Shared types and 7-segment glyphs for the keypad code lock.
package password_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ENTRY,
    ST_OPEN,
    ST_FAIL,
    ST_LOCKOUT
  } state_t;

  localparam int unsigned SEG_W = 7;

  // Glyphs are active-high here (bit6=a ... bit0=g); the pads are active-low.
  localparam logic [SEG_W-1:0] GLYPH_P     = 7'b1100111;
  localparam logic [SEG_W-1:0] GLYPH_A     = 7'b1110111;
  localparam logic [SEG_W-1:0] GLYPH_S     = 7'b1011011;
  localparam logic [SEG_W-1:0] GLYPH_F     = 7'b1000111;
  localparam logic [SEG_W-1:0] GLYPH_I     = 7'b0110000;
  localparam logic [SEG_W-1:0] GLYPH_L     = 7'b0001110;
  localparam logic [SEG_W-1:0] GLYPH_DASH  = 7'b0000001;
  localparam logic [SEG_W-1:0] GLYPH_BLANK = 7'b0000000;

  // Convert an active-high glyph to the active-low pad level.
  function automatic logic [SEG_W-1:0] seg_drive(input logic [SEG_W-1:0] glyph);
    return ~glyph;
  endfunction

endpackage

// File: rtl/pw_timer.sv
// Loadable down-counter that parks at zero; shared by timeout, open and lockout phases.
module pw_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero_c
);

  logic [W-1:0] count;

  // Load has priority; otherwise count down and hold at zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign zero_c = (count == '0);

endmodule

// File: rtl/password_lock_fsm.sv
// Keypad code-lock controller: digit entry, open/fail decision, lockout and display.
module password_lock_fsm
  import password_pkg::*;
#(
  parameter int unsigned               DIGITS      = 4,
  parameter int unsigned               DW          = 4,
  parameter logic [DIGITS*DW-1:0]      CODE        = 16'h1980,
  parameter int unsigned               MAX_FAIL    = 3,
  parameter int unsigned               TIMEOUT_CYC = 50_000_000,
  parameter int unsigned               OPEN_CYC    = 250_000_000,
  parameter int unsigned               LOCK_CYC    = 500_000_000
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [DW-1:0]                digit_in,
  input  logic                         digit_valid,
  input  logic                         clear,
  output logic                         unlocked,
  output logic                         locked_out,
  output logic                         fail_pulse,
  output logic [$clog2(DIGITS+1)-1:0]  progress,
  output logic [6:0]                   seg3,
  output logic [6:0]                   seg2,
  output logic [6:0]                   seg1,
  output logic [6:0]                   seg0
);

  localparam int unsigned PW = $clog2(DIGITS + 1);
  localparam int unsigned FW = $clog2(MAX_FAIL + 1);
  localparam int unsigned MAX_CYC =
    (TIMEOUT_CYC > OPEN_CYC) ? ((TIMEOUT_CYC > LOCK_CYC) ? TIMEOUT_CYC : LOCK_CYC)
                             : ((OPEN_CYC > LOCK_CYC) ? OPEN_CYC : LOCK_CYC);
  localparam int unsigned TW = ($clog2(MAX_CYC) < 1) ? 1 : $clog2(MAX_CYC);

  // Phases last N cycles from the loading edge, so the counter is loaded with N-1
  // and the exit happens on the edge after it reads zero.
  localparam logic [TW-1:0] LD_TIMEOUT = TW'(TIMEOUT_CYC - 1);
  localparam logic [TW-1:0] LD_OPEN    = TW'(OPEN_CYC - 1);
  localparam logic [TW-1:0] LD_LOCK    = TW'(LOCK_CYC - 1);

  state_t                state_q, state_d;
  logic [PW-1:0]         progress_d;
  logic                  mismatch_q, mismatch_d;
  logic [FW-1:0]         fail_q, fail_d, fail_inc;
  logic                  digit_bad;
  logic                  tmr_load;
  logic [TW-1:0]         tmr_val;
  logic                  tmr_zero;
  logic                  unlocked_d, locked_out_d, fail_pulse_d;
  logic [3:0][SEG_W-1:0] seg_q, seg_d;

  // Expected code digit at entry position idx; first entered digit is the MS digit.
  function automatic logic [DW-1:0] code_digit(input logic [PW-1:0] idx);
    logic [DW-1:0] d;
    d = '0;
    for (int k = 0; k < int'(DIGITS); k++) begin
      if (idx == PW'(k)) d = CODE[(int'(DIGITS) - 1 - k) * int'(DW) +: DW];
    end
    return d;
  endfunction

  pw_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero_c   (tmr_zero)
  );

  // State, attempt bookkeeping and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      progress   <= '0;
      mismatch_q <= 1'b0;
      fail_q     <= '0;
      unlocked   <= 1'b0;
      locked_out <= 1'b0;
      fail_pulse <= 1'b0;
      seg_q      <= {4{seg_drive(GLYPH_BLANK)}};
    end else begin
      state_q    <= state_d;
      progress   <= progress_d;
      mismatch_q <= mismatch_d;
      fail_q     <= fail_d;
      unlocked   <= unlocked_d;
      locked_out <= locked_out_d;
      fail_pulse <= fail_pulse_d;
      seg_q      <= seg_d;
    end
  end

  // Next state, timer control and next output values.
  always_comb begin
    state_d    = state_q;
    progress_d = progress;
    mismatch_d = mismatch_q;
    fail_d     = fail_q;
    tmr_load   = 1'b0;
    tmr_val    = '0;
    digit_bad  = (digit_in != code_digit(progress));
    fail_inc   = (fail_q == FW'(MAX_FAIL)) ? fail_q : fail_q + FW'(1);
    seg_d      = {4{seg_drive(GLYPH_BLANK)}};

    unique case (state_q)
      ST_IDLE: begin
        if (clear) begin
          progress_d = '0;
        end else if (digit_valid) begin
          progress_d = PW'(1);
          mismatch_d = digit_bad;
          state_d    = ST_ENTRY;
          tmr_load   = 1'b1;
          tmr_val    = LD_TIMEOUT;
        end
      end
      ST_ENTRY: begin
        if (clear) begin
          progress_d = '0;
          state_d    = ST_IDLE;
        end else if (digit_valid) begin
          mismatch_d = mismatch_q | digit_bad;
          progress_d = progress + PW'(1);
          if (progress == PW'(DIGITS - 1)) begin
            if (mismatch_d) begin
              state_d = ST_FAIL;
            end else begin
              state_d  = ST_OPEN;
              fail_d   = '0;
              tmr_load = 1'b1;
              tmr_val  = LD_OPEN;
            end
          end else begin
            tmr_load = 1'b1;
            tmr_val  = LD_TIMEOUT;
          end
        end else if (tmr_zero) begin
          progress_d = '0;
          state_d    = ST_IDLE;
        end
      end
      ST_OPEN: begin
        if (clear || tmr_zero) begin
          progress_d = '0;
          state_d    = ST_IDLE;
        end
      end
      ST_FAIL: begin
        fail_d     = fail_inc;
        progress_d = '0;
        if (fail_inc == FW'(MAX_FAIL)) begin
          state_d  = ST_LOCKOUT;
          tmr_load = 1'b1;
          tmr_val  = LD_LOCK;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOCKOUT: begin
        if (tmr_zero) begin
          fail_d  = '0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        progress_d = '0;
        state_d    = ST_IDLE;
      end
    endcase

    unlocked_d   = (state_d == ST_OPEN);
    locked_out_d = (state_d == ST_LOCKOUT);
    fail_pulse_d = (state_d == ST_FAIL);

    unique case (state_d)
      ST_OPEN: begin
        seg_d = {seg_drive(GLYPH_P), seg_drive(GLYPH_A),
                 seg_drive(GLYPH_S), seg_drive(GLYPH_S)};
      end
      ST_FAIL, ST_LOCKOUT: begin
        seg_d = {seg_drive(GLYPH_F), seg_drive(GLYPH_A),
                 seg_drive(GLYPH_I), seg_drive(GLYPH_L)};
      end
      default: begin
        for (int k = 0; k < 4; k++) begin
          seg_d[k] = (PW'(k) < progress_d) ? seg_drive(GLYPH_DASH) : seg_drive(GLYPH_BLANK);
        end
      end
    endcase
  end

  assign seg3 = seg_q[3];
  assign seg2 = seg_q[2];
  assign seg1 = seg_q[1];
  assign seg0 = seg_q[0];

endmodule

// File: tb/tb_password_lock_fsm.sv
// Bench for password_lock_fsm: vector table, directed corner sequences, random run vs model.
module tb_password_lock_fsm;

  localparam int DIGITS      = 4;
  localparam int MAX_FAIL    = 3;
  localparam int TIMEOUT_CYC = 10;
  localparam int OPEN_CYC    = 15;
  localparam int LOCK_CYC    = 20;

  // Active-low pad levels for each glyph.
  localparam logic [27:0] D_BLANK = {4{7'h7F}};
  localparam logic [27:0] D_PASS  = {7'h18, 7'h08, 7'h24, 7'h24};
  localparam logic [27:0] D_FAIL  = {7'h38, 7'h08, 7'h4F, 7'h71};

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] digit_in = '0;
  logic       digit_valid = 1'b0;
  logic       clear = 1'b0;
  logic       unlocked, locked_out, fail_pulse;
  logic [2:0] progress;
  logic [6:0] seg3, seg2, seg1, seg0;
  logic [33:0] got;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  password_lock_fsm #(
    .DIGITS(4), .DW(4), .CODE(16'h1980), .MAX_FAIL(3),
    .TIMEOUT_CYC(10), .OPEN_CYC(15), .LOCK_CYC(20)
  ) dut (
    .clk(clk), .reset(reset), .digit_in(digit_in), .digit_valid(digit_valid),
    .clear(clear), .unlocked(unlocked), .locked_out(locked_out),
    .fail_pulse(fail_pulse), .progress(progress),
    .seg3(seg3), .seg2(seg2), .seg1(seg1), .seg0(seg0)
  );

  assign got = {unlocked, locked_out, fail_pulse, progress, seg3, seg2, seg1, seg0};

  // ---------------- reference model (what the lock should be doing) ----------------
  localparam int M_IDLE = 0, M_ENTRY = 1, M_OPEN = 2, M_FAIL = 3, M_LOCK = 4;
  int code_d[4] = '{1, 9, 8, 0};
  int m_mode, m_idle, m_age, m_fails;
  int m_q[$];

  function automatic logic [27:0] d_dash(input int n);
    logic [27:0] r;
    r = D_BLANK;
    for (int k = 0; k < 4; k++) if (k < n) r[k*7 +: 7] = 7'h7E;
    return r;
  endfunction

  function automatic logic [33:0] mk(input bit unl, input bit lo, input bit fp,
                                     input int prog, input logic [27:0] seg);
    return {unl, lo, fp, 3'(prog), seg};
  endfunction

  function automatic bit q_matches();
    for (int k = 0; k < DIGITS; k++) if (m_q[k] != code_d[k]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_idle = 0; m_age = 0; m_fails = 0;
    m_q.delete();
  endtask

  task automatic model_step(input bit clr, input bit dv, input int d);
    case (m_mode)
      M_IDLE: if (!clr && dv) begin
        m_q.delete(); m_q.push_back(d); m_idle = 0; m_mode = M_ENTRY;
      end
      M_ENTRY: begin
        if (clr) begin
          m_q.delete(); m_mode = M_IDLE;
        end else if (dv) begin
          m_q.push_back(d); m_idle = 0;
          if (m_q.size() == DIGITS) begin
            if (q_matches()) begin m_mode = M_OPEN; m_age = 0; m_fails = 0; end
            else m_mode = M_FAIL;
          end
        end else begin
          m_idle++;
          if (m_idle >= TIMEOUT_CYC) begin m_q.delete(); m_mode = M_IDLE; end
        end
      end
      M_OPEN: begin
        m_age++;
        if (clr || m_age >= OPEN_CYC) begin m_q.delete(); m_mode = M_IDLE; end
      end
      M_FAIL: begin
        if (m_fails < MAX_FAIL) m_fails++;
        m_q.delete();
        if (m_fails == MAX_FAIL) begin m_mode = M_LOCK; m_age = 0; end
        else m_mode = M_IDLE;
      end
      default: begin
        m_age++;
        if (m_age >= LOCK_CYC) begin m_mode = M_IDLE; m_fails = 0; end
      end
    endcase
  endtask

  function automatic logic [33:0] model_exp();
    logic [27:0] s;
    if (m_mode == M_OPEN) s = D_PASS;
    else if (m_mode == M_FAIL || m_mode == M_LOCK) s = D_FAIL;
    else s = d_dash(m_q.size());
    return mk(m_mode == M_OPEN, m_mode == M_LOCK, m_mode == M_FAIL, m_q.size(), s);
  endfunction

  // ---------------- checking and driving ----------------
  task automatic check(input string name, input logic [33:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h required=%h", name, got, exp);
    end
  endtask

  task automatic step(input bit clr, input bit dv, input int d, input string name);
    clear = clr; digit_valid = dv; digit_in = 4'(d);
    @(posedge clk);
    #1;
    model_step(clr, dv, d);
    check({name, " model"}, model_exp());
  endtask

  task automatic enter(input int a, input int b, input int c, input int e, input string name);
    step(0, 1, a, name); step(0, 1, b, name); step(0, 1, c, name); step(0, 1, e, name);
  endtask

  task automatic async_reset(input string name);
    clear = 1'b0; digit_valid = 1'b0;
    #2 reset = 1'b0;
    #2 check({name, " immediate"}, mk(0, 0, 0, 0, D_BLANK));
    @(posedge clk);
    #1 check({name, " held"}, mk(0, 0, 0, 0, D_BLANK));
    reset = 1'b1;
    model_reset();
  endtask

  typedef struct {
    bit          clr;
    bit          dv;
    int          d;
    logic [33:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input bit clr, input bit dv, input int d, input logic [33:0] exp);
    vec_t v;
    v.clr = clr; v.dv = dv; v.d = d; v.exp = exp;
    vecs.push_back(v);
  endtask

  initial begin
    // Table: correct code, clear priority, wrong code with no early indication.
    add_vec(0, 1, 1, mk(0, 0, 0, 1, d_dash(1)));
    add_vec(0, 1, 9, mk(0, 0, 0, 2, d_dash(2)));
    add_vec(0, 0, 0, mk(0, 0, 0, 2, d_dash(2)));
    add_vec(0, 1, 8, mk(0, 0, 0, 3, d_dash(3)));
    add_vec(0, 1, 0, mk(1, 0, 0, 4, D_PASS));
    add_vec(0, 1, 5, mk(1, 0, 0, 4, D_PASS));
    add_vec(1, 0, 0, mk(0, 0, 0, 0, D_BLANK));
    add_vec(1, 1, 1, mk(0, 0, 0, 0, D_BLANK));
    add_vec(0, 1, 1, mk(0, 0, 0, 1, d_dash(1)));
    add_vec(1, 1, 9, mk(0, 0, 0, 0, D_BLANK));
    add_vec(0, 1, 1, mk(0, 0, 0, 1, d_dash(1)));
    add_vec(0, 1, 2, mk(0, 0, 0, 2, d_dash(2)));
    add_vec(0, 1, 8, mk(0, 0, 0, 3, d_dash(3)));
    add_vec(0, 1, 0, mk(0, 0, 1, 4, D_FAIL));
    add_vec(0, 0, 0, mk(0, 0, 0, 0, D_BLANK));

    model_reset();
    repeat (2) @(posedge clk);
    #1 check("reset state", mk(0, 0, 0, 0, D_BLANK));
    reset = 1'b1;

    foreach (vecs[i]) begin
      step(vecs[i].clr, vecs[i].dv, vecs[i].d, $sformatf("vec%0d", i));
      check($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Inter-digit timeout: back to IDLE exactly TIMEOUT_CYC idle cycles after the last digit.
    step(0, 1, 1, "to"); step(0, 1, 9, "to");
    for (int i = 1; i <= TIMEOUT_CYC; i++) begin
      step(0, 0, 0, "to idle");
      check($sformatf("timeout c%0d", i),
            (i < TIMEOUT_CYC) ? mk(0, 0, 0, 2, d_dash(2)) : mk(0, 0, 0, 0, D_BLANK));
    end

    // Two more wrong codes lock out: the earlier failure survived clear and timeout.
    enter(1, 2, 8, 0, "wrong2");
    step(0, 0, 0, "wrong2 idle");
    check("after 2nd fail", mk(0, 0, 0, 0, D_BLANK));
    enter(1, 2, 8, 0, "wrong3");
    check("3rd fail pulse", mk(0, 0, 1, 4, D_FAIL));
    step(0, 0, 0, "lock enter");
    check("lockout entered", mk(0, 1, 0, 0, D_FAIL));
    for (int i = 1; i <= LOCK_CYC; i++) begin
      if (i <= 4) step(0, 1, code_d[i-1], "lock code");
      else step(i == 6, 0, 0, "lock wait");
      check($sformatf("lockout c%0d", i),
            (i < LOCK_CYC) ? mk(0, 1, 0, 0, D_FAIL) : mk(0, 0, 0, 0, D_BLANK));
    end
    enter(1, 9, 8, 0, "post lock");
    check("open after lockout", mk(1, 0, 0, 4, D_PASS));

    // Auto-relock after exactly OPEN_CYC cycles.
    for (int i = 1; i <= OPEN_CYC; i++) begin
      step(0, 0, 0, "open hold");
      check($sformatf("open c%0d", i),
            (i < OPEN_CYC) ? mk(1, 0, 0, 4, D_PASS) : mk(0, 0, 0, 0, D_BLANK));
    end

    // Clear while open relocks on the next edge.
    enter(1, 9, 8, 0, "reopen");
    for (int i = 1; i <= 5; i++) begin
      step(i == 5, 0, 0, "open clr");
      check($sformatf("open clear c%0d", i),
            (i < 5) ? mk(1, 0, 0, 4, D_PASS) : mk(0, 0, 0, 0, D_BLANK));
    end

    // Asynchronous reset mid-entry and mid-lockout.
    step(0, 1, 1, "pre rst"); step(0, 1, 9, "pre rst");
    async_reset("reset mid-entry");
    for (int r = 0; r < 3; r++) begin
      enter(1, 2, 8, 0, "rst wrong");
      step(0, 0, 0, "rst wrong idle");
    end
    check("lockout before reset", mk(0, 1, 0, 0, D_FAIL));
    step(0, 0, 0, "lock idle");
    async_reset("reset mid-lockout");
    enter(1, 9, 8, 0, "after rst");
    check("open after reset", mk(1, 0, 0, 4, D_PASS));
    step(1, 0, 0, "close");

    // Randomized run against the reference model.
    for (int n = 0; n < 3000; n++) begin
      bit clr, dv;
      int d;
      clr = ($urandom_range(0, 24) == 0);
      dv  = ($urandom_range(0, 1) == 1);
      if (m_q.size() < DIGITS && $urandom_range(0, 3) != 0) d = code_d[m_q.size()];
      else d = int'($urandom_range(0, 15));
      step(clr, dv, d, $sformatf("rand%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
